// File: rtl/psw_debounce.sv
// Push-switch conditioner: 2-flop synchroniser, sample-tick prescaler and debounce FSM.
// Emits a clean active-low level, one-cycle press/release pulses and a long-press flag.
module psw_debounce #(
  parameter int C_F_CK     = 135_000_000,
  parameter int C_DBG_ACC  = 0,
  parameter int C_STABLE_N = 8,
  parameter int C_LONG_N   = 1000
) (
  input  logic CK_i,
  input  logic XARST_i,
  input  logic XPSW_i,
  output logic XPSW_o,
  output logic PRESS_o,
  output logic REL_o,
  output logic LONG_o
);

  localparam int C_SMP_CK_N = (C_DBG_ACC != 0) ? 4 : C_F_CK / 1000;
  localparam int PW = (C_SMP_CK_N > 1) ? $clog2(C_SMP_CK_N) : 1;
  localparam int CW = $clog2(C_STABLE_N) + 1;
  localparam int LW = $clog2(C_LONG_N) + 1;
  localparam logic [PW-1:0] P_LAST   = PW'(C_SMP_CK_N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_STABLE_N - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(C_LONG_N);
  localparam logic [LW-1:0] LONG_PRE = LW'(C_LONG_N - 1);

  typedef enum logic [1:0] {
    ST_REL   = 2'd0,
    ST_P_CHK = 2'd1,
    ST_PRS   = 2'd2,
    ST_R_CHK = 2'd3
  } state_t;

  logic          s1;
  logic          sw;
  logic [PW-1:0] pcnt;
  logic          ee;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] long_cnt;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      s1 <= 1'b1;
      sw <= 1'b1;
    end else begin
      s1 <= XPSW_i;
      sw <= s1;
    end
  end

  // Free-running; the FSM only advances on the wrap cycle.
  assign ee = (pcnt == P_LAST);

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      pcnt <= '0;
    end else if (ee) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state    <= ST_REL;
      cnt      <= '0;
      long_cnt <= '0;
      XPSW_o   <= 1'b1;
      PRESS_o  <= 1'b0;
      REL_o    <= 1'b0;
      LONG_o   <= 1'b0;
    end else begin
      PRESS_o <= 1'b0;
      REL_o   <= 1'b0;
      if (ee) begin
        case (state)
          ST_REL: begin
            if (!sw) begin
              state <= ST_P_CHK;
              cnt   <= CW'(1);
            end
          end
          ST_P_CHK: begin
            if (sw) begin
              state <= ST_REL;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state    <= ST_PRS;
              XPSW_o   <= 1'b0;
              PRESS_o  <= 1'b1;
              cnt      <= '0;
              long_cnt <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_PRS: begin
            if (sw) begin
              state <= ST_R_CHK;
              cnt   <= CW'(1);
            end else begin
              if (long_cnt != LONG_MAX) long_cnt <= long_cnt + LW'(1);
              if (long_cnt >= LONG_PRE) LONG_o <= 1'b1;
            end
          end
          ST_R_CHK: begin
            // long_cnt is deliberately left alone here so a bounce resumes the hold time.
            if (!sw) begin
              state <= ST_PRS;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state    <= ST_REL;
              XPSW_o   <= 1'b1;
              REL_o    <= 1'b1;
              LONG_o   <= 1'b0;
              cnt      <= '0;
              long_cnt <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= ST_REL;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psw_debounce.sv
// Bench for psw_debounce (debug sample rate): sample-run-length reference model plus directed latency checks.
module tb_psw_debounce;

  localparam int STABLE = 8;
  localparam int LONGN  = 16;

  logic CK_i    = 1'b0;
  logic XARST_i = 1'b0;
  logic XPSW_i  = 1'b1;
  logic XPSW_o, PRESS_o, REL_o, LONG_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 CK_i = ~CK_i;

  psw_debounce #(
    .C_F_CK    (135_000_000),
    .C_DBG_ACC (1),
    .C_STABLE_N(STABLE),
    .C_LONG_N  (LONGN)
  ) dut (
    .CK_i   (CK_i),
    .XARST_i(XARST_i),
    .XPSW_i (XPSW_i),
    .XPSW_o (XPSW_o),
    .PRESS_o(PRESS_o),
    .REL_o  (REL_o),
    .LONG_o (LONG_o)
  );

  // Reference model: raw input delayed two clocks, sampled every 4th clock after reset;
  // the level flips after STABLE consecutive opposite samples; hold time counts
  // pressed samples whose predecessor sample was also pressed.
  logic m_s1, m_sw, m_lvl, m_prev, m_press, m_rel, m_longo;
  int   m_edges, m_run, m_long;

  int press_cnt = 0, rel_cnt = 0;
  int press_cyc = 0, fall_cyc = 0, rise_cyc = 0, rel_cyc = 0, lrise_cyc = 0, lfall_cyc = 0;
  logic prev_x = 1'b1, prev_l = 1'b0;

  task automatic model_reset();
    m_s1 = 1'b1; m_sw = 1'b1; m_lvl = 1'b1; m_prev = 1'b0;
    m_press = 1'b0; m_rel = 1'b0; m_longo = 1'b0;
    m_edges = 0; m_run = 0; m_long = 0;
  endtask

  task automatic model_edge(input logic din);
    logic smp;
    bit   tick;
    smp  = m_sw;
    tick = (m_edges % 4) == 3;
    m_edges++;
    m_sw = m_s1;
    m_s1 = din;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (tick) begin
      if (m_lvl == 1'b0 && smp == 1'b0 && m_prev == 1'b0) m_long++;
      if (smp != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == STABLE) begin
        m_lvl = smp;
        m_run = 0;
        if (smp == 1'b0) begin
          m_press = 1'b1;
          m_long  = 0;
        end else begin
          m_rel = 1'b1;
        end
      end
      m_prev  = smp;
      m_longo = (m_lvl == 1'b0) && (m_long >= LONGN);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    vectors++;
    assert (got >= lo && got <= hi) else begin
      miscompares++;
      $error("FAIL %s got=%0d exp=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic step(input logic din);
    XPSW_i = din;
    @(posedge CK_i);
    if (!XARST_i) model_reset();
    else model_edge(din);
    cyc++;
    @(negedge CK_i);
    chk("outputs", {28'd0, XPSW_o, PRESS_o, REL_o, LONG_o},
        {28'd0, m_lvl, m_press, m_rel, m_longo});
    chk("press_rel_excl", {31'd0, PRESS_o & REL_o}, 32'd0);
    if (PRESS_o) begin press_cnt++; press_cyc = cyc; end
    if (REL_o)   begin rel_cnt++;   rel_cyc   = cyc; end
    if (prev_x && !XPSW_o) fall_cyc = cyc;
    if (!prev_x && XPSW_o) rise_cyc = cyc;
    if (!prev_l && LONG_o) lrise_cyc = cyc;
    if (prev_l && !LONG_o) lfall_cyc = cyc;
    prev_x = XPSW_o;
    prev_l = LONG_o;
  endtask

  task automatic hold(input logic din, input int n);
    for (int i = 0; i < n; i++) step(din);
  endtask

  initial begin
    int t_edge, p0, r0, seg, lvl_r;
    model_reset();
    @(negedge CK_i);
    chk("reset_state", {28'd0, XPSW_o, PRESS_o, REL_o, LONG_o}, 32'h8);

    // Reset held while the switch chatters.
    for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)));
    XARST_i = 1'b1;
    hold(1'b1, 10);

    // Clean press and release with long-press in between.
    p0 = press_cnt; r0 = rel_cnt;
    t_edge = cyc;
    hold(1'b0, 200);
    chk_rng("press_latency", fall_cyc - t_edge, 31, 34);
    chk("press_pulse_at_fall", press_cyc, fall_cyc);
    chk("press_count", press_cnt - p0, 1);
    chk("long_rise_delay", lrise_cyc - fall_cyc, 64);
    t_edge = cyc;
    hold(1'b1, 200);
    chk_rng("release_latency", rise_cyc - t_edge, 31, 34);
    chk("rel_count", rel_cnt - r0, 1);
    chk("long_fall_with_rel", lfall_cyc, rel_cyc);

    // Glitch shorter than the stability window.
    p0 = press_cnt;
    hold(1'b0, 20);
    hold(1'b1, 60);
    chk("glitch_no_press", press_cnt - p0, 0);

    // Bounce then settle low.
    p0 = press_cnt;
    for (int i = 0; i < 16; i++) hold(1'(i % 2), 5);
    t_edge = cyc;
    hold(1'b0, 100);
    chk("bounce_one_press", press_cnt - p0, 1);
    chk_rng("bounce_settle_delay", press_cyc - t_edge, 29, 1000);
    hold(1'b1, 60);

    // Randomised segments against the model.
    for (int i = 0; i < 60; i++) begin
      seg   = $urandom_range(1, 70);
      lvl_r = $urandom_range(0, 1);
      hold(1'(lvl_r), seg);
    end
    hold(1'b1, 60);
    chk("press_rel_balance", press_cnt, rel_cnt);

    // Reset in the middle of a long press.
    for (int i = 0; i < 200 && !LONG_o; i++) step(1'b0);
    chk("long_before_reset", {31'd0, LONG_o}, 32'd1);
    r0 = rel_cnt; p0 = press_cnt;
    XARST_i = 1'b0;
    #1;
    chk("reset_immediate", {28'd0, XPSW_o, PRESS_o, REL_o, LONG_o}, 32'h8);
    hold(1'b0, 3);
    XARST_i = 1'b1;
    t_edge = cyc;
    hold(1'b0, 60);
    chk("no_rel_on_reset", rel_cnt - r0, 0);
    chk("press_after_reset", press_cnt - p0, 1);
    chk_rng("press_after_reset_latency", press_cyc - t_edge, 31, 34);
    hold(1'b1, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
